// File: rtl/uart_pkg.sv
// Shared UART frame constants and transmitter FSM state encoding.
package uart_pkg;

    localparam int unsigned DATA_BITS        = 8;
    localparam int unsigned STOP_BITS        = 1;
    localparam int unsigned DEFAULT_BAUD_DIV = 434;
    localparam int unsigned STATE_W          = 3;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_START  = 3'd1;
    localparam state_t ST_DATA   = 3'd2;
    localparam state_t ST_PARITY = 3'd3;
    localparam state_t ST_STOP   = 3'd4;

endpackage

// File: rtl/tx_fifo.sv
// Byte FIFO with wrap-bit pointers; full/empty/count are registered.
module tx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data_c,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic             wr_fire, rd_fire;

    // Writes while full are dropped; a pop never frees room for a same-edge write.
    always_comb begin
        wr_fire    = wr_en && !full;
        rd_fire    = rd_en && !empty;
        wr_ptr_nxt = wr_ptr + PW'(wr_fire);
        rd_ptr_nxt = rd_ptr + PW'(rd_fire);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            count  <= wr_ptr_nxt - rd_ptr_nxt;
            empty  <= (wr_ptr_nxt == rd_ptr_nxt);
            full   <= (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                      (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    assign rd_data_c = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_tx_module.sv
// FIFO-buffered 8N1 UART transmitter; define UART_TX_PARITY_EN to add an even-parity bit.
module uart_tx_module
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV   = DEFAULT_BAUD_DIV,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       TX_En_Sig,
    input  logic [7:0] TX_Data,
    output logic       TX_Ready,
    output logic       TX_Busy,
    output logic       TX_Done_Sig,
    output logic       TX_Pin_Out
);

    localparam int unsigned BW = $clog2(BAUD_DIV);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    state_t               state, state_nxt;
    logic [BW-1:0]        baud_cnt, baud_nxt;
    logic [2:0]           bit_idx, idx_nxt;
    logic [DATA_BITS-1:0] shreg, shreg_nxt;
    logic                 pin_nxt, done_nxt, baud_last;
    logic                 fifo_pop_c, fifo_full, fifo_empty;
    logic [7:0]           fifo_head_c;
    logic [CW-1:0]        fifo_count;
`ifdef UART_TX_PARITY_EN
    logic                 parity_bit, parity_nxt;
`endif

    tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (CLK),
        .rst       (RST),
        .wr_en     (TX_En_Sig),
        .wr_data   (TX_Data),
        .rd_en     (fifo_pop_c),
        .rd_data_c (fifo_head_c),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign TX_Ready  = !fifo_full;
    assign TX_Busy   = (state != ST_IDLE) || (fifo_count != '0);
    assign baud_last = (baud_cnt == BW'(BAUD_DIV - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= ST_IDLE;
            baud_cnt    <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            TX_Pin_Out  <= 1'b1;
            TX_Done_Sig <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit  <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            baud_cnt    <= baud_nxt;
            bit_idx     <= idx_nxt;
            shreg       <= shreg_nxt;
            TX_Pin_Out  <= pin_nxt;
            TX_Done_Sig <= done_nxt;
`ifdef UART_TX_PARITY_EN
            parity_bit  <= parity_nxt;
`endif
        end
    end

    // Pin value is computed one edge ahead so the line comes straight from a flop.
    always_comb begin
        state_nxt  = state;
        baud_nxt   = baud_cnt;
        idx_nxt    = bit_idx;
        shreg_nxt  = shreg;
        pin_nxt    = TX_Pin_Out;
        done_nxt   = 1'b0;
        fifo_pop_c = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_nxt = parity_bit;
`endif
        case (state)
            ST_IDLE: begin
                baud_nxt = '0;
                pin_nxt  = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop_c = 1'b1;
                    shreg_nxt  = fifo_head_c;
                    pin_nxt    = 1'b0;
                    state_nxt  = ST_START;
`ifdef UART_TX_PARITY_EN
                    parity_nxt = ^fifo_head_c;
`endif
                end
            end
            ST_START: begin
                if (baud_last) begin
                    baud_nxt  = '0;
                    idx_nxt   = '0;
                    pin_nxt   = shreg[0];
                    state_nxt = ST_DATA;
                end else begin
                    baud_nxt = baud_cnt + BW'(1);
                end
            end
            ST_DATA: begin
                if (baud_last) begin
                    baud_nxt  = '0;
                    shreg_nxt = shreg >> 1;
                    idx_nxt   = bit_idx + 3'd1;
                    if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        pin_nxt   = parity_bit;
                        state_nxt = ST_PARITY;
`else
                        pin_nxt   = 1'b1;
                        state_nxt = ST_STOP;
`endif
                    end else begin
                        pin_nxt = shreg[1];
                    end
                end else begin
                    baud_nxt = baud_cnt + BW'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_last) begin
                    baud_nxt  = '0;
                    pin_nxt   = 1'b1;
                    state_nxt = ST_STOP;
                end else begin
                    baud_nxt = baud_cnt + BW'(1);
                end
            end
`endif
            // Chaining straight into START keeps back-to-back frames gapless.
            ST_STOP: begin
                if (baud_last) begin
                    baud_nxt = '0;
                    done_nxt = 1'b1;
                    if (!fifo_empty) begin
                        fifo_pop_c = 1'b1;
                        shreg_nxt  = fifo_head_c;
                        pin_nxt    = 1'b0;
                        state_nxt  = ST_START;
`ifdef UART_TX_PARITY_EN
                        parity_nxt = ^fifo_head_c;
`endif
                    end else begin
                        pin_nxt   = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    baud_nxt = baud_cnt + BW'(1);
                end
            end
            default: begin
                baud_nxt  = '0;
                pin_nxt   = 1'b1;
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_module.sv
// Self-checking bench for uart_tx_module against a frame-level reference model.
module tb_uart_tx_module;

    localparam int B     = 4;
    localparam int DEPTH = 4;
    localparam int B_DEF = 434;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int NBITS = PAR ? 11 : 10;
    localparam int FRAME = NBITS * B;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       tx_en, tx_ready, tx_busy, tx_done, tx_pin;
    logic [7:0] tx_data;
    logic       d_en, d_ready, d_busy, d_done, d_pin;
    logic [7:0] d_data;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: queue of accepted bytes plus position within the current frame.
    logic [7:0] m_q[$];
    logic [7:0] m_cur;
    bit         m_active = 1'b0;
    bit         m_done   = 1'b0;
    int         m_pos    = 0;

    always #5 CLK = ~CLK;

    uart_tx_module #(.BAUD_DIV(B), .FIFO_DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .TX_En_Sig(tx_en), .TX_Data(tx_data),
        .TX_Ready(tx_ready), .TX_Busy(tx_busy), .TX_Done_Sig(tx_done), .TX_Pin_Out(tx_pin)
    );

    uart_tx_module #(.BAUD_DIV(B_DEF), .FIFO_DEPTH(DEPTH)) dut_def (
        .CLK(CLK), .RST(RST), .TX_En_Sig(d_en), .TX_Data(d_data),
        .TX_Ready(d_ready), .TX_Busy(d_busy), .TX_Done_Sig(d_done), .TX_Pin_Out(d_pin)
    );

    // Line level for frame bit idx: start, data LSB first, optional parity, stop.
    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        logic [7:0] v;
        v = b;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return v[idx-1];
        if (PAR && idx == 9) return ^v;
        return 1'b1;
    endfunction

    // Expected {pin, done, busy, ready} after the most recent edge.
    function automatic logic [3:0] exp_vec();
        logic p;
        p = m_active ? frame_bit(m_cur, m_pos / B) : 1'b1;
        return {p, m_done, m_active || (m_q.size() > 0), m_q.size() < DEPTH};
    endfunction

    task automatic step(input logic en, input logic [7:0] d);
        bit ending, full_before;
        tx_en   = en;
        tx_data = d;
        @(posedge CLK);
        full_before = (m_q.size() == DEPTH);
        ending      = m_active && (m_pos == FRAME - 1);
        if (m_active && !ending) m_pos++;
        if (ending) m_active = 1'b0;
        if (!m_active && m_q.size() > 0) begin
            m_cur    = m_q.pop_front();
            m_active = 1'b1;
            m_pos    = 0;
        end
        if (en && !full_before) m_q.push_back(d);
        m_done = ending;
        #1;
        tx_en = 1'b0;
        cyc++;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge CLK);
        #1;
        n_tests++;
        if ({tx_pin, tx_done, tx_busy, tx_ready} !== 4'b1001) begin
            n_fail++;
            $display("FAIL reset pin/done/busy/ready got=%b want=1001", {tx_pin, tx_done, tx_busy, tx_ready});
        end
        n_tests++;
        if ({d_pin, d_done, d_busy, d_ready} !== 4'b1001) begin
            n_fail++;
            $display("FAIL reset_def pin/done/busy/ready got=%b want=1001", {d_pin, d_done, d_busy, d_ready});
        end
        RST = 1'b0;
        step(1'b0, 8'h00);
    endtask

    task automatic test_single_byte();
        int k, first_low, done_at, ndone;
        logic [3:0] act;
        first_low = -1; done_at = -1; ndone = 0; k = cyc + 1;
        for (int i = 0; i < FRAME + 20; i++) begin
            step(i == 0, 8'hA5);
            act = {tx_pin, tx_done, tx_busy, tx_ready};
            n_tests++;
            if (act !== exp_vec()) begin
                n_fail++;
                $display("FAIL single cyc=%0d pin/done/busy/ready got=%b want=%b", cyc, act, exp_vec());
            end
            if (tx_pin === 1'b0 && first_low < 0) first_low = cyc;
            if (tx_done === 1'b1) begin ndone++; done_at = cyc; end
        end
        n_tests++;
        if (first_low !== k + 1) begin
            n_fail++;
            $display("FAIL single_latency first low at %0d want %0d", first_low, k + 1);
        end
        n_tests++;
        if (done_at - first_low !== FRAME) begin
            n_fail++;
            $display("FAIL single_frame_len got %0d want %0d", done_at - first_low, FRAME);
        end
        n_tests++;
        if (ndone !== 1) begin
            n_fail++;
            $display("FAIL single_done_count got %0d want 1", ndone);
        end
    endtask

    task automatic test_back_to_back();
        int first_low, last_done, ndone;
        logic [3:0] act;
        first_low = -1; last_done = -1; ndone = 0;
        for (int i = 0; i < 3 * FRAME + 20; i++) begin
            step(i < 3, 8'(i + 1));
            act = {tx_pin, tx_done, tx_busy, tx_ready};
            n_tests++;
            if (act !== exp_vec()) begin
                n_fail++;
                $display("FAIL b2b cyc=%0d pin/done/busy/ready got=%b want=%b", cyc, act, exp_vec());
            end
            if (tx_pin === 1'b0 && first_low < 0) first_low = cyc;
            if (tx_done === 1'b1) begin ndone++; last_done = cyc; end
        end
        n_tests++;
        if (ndone !== 3) begin
            n_fail++;
            $display("FAIL b2b_done_count got %0d want 3", ndone);
        end
        n_tests++;
        if (last_done - first_low !== 3 * FRAME) begin
            n_fail++;
            $display("FAIL b2b_span got %0d want %0d", last_done - first_low, 3 * FRAME);
        end
    endtask

    task automatic test_overflow();
        int ndone;
        bit saw_full;
        logic [3:0] act;
        ndone = 0; saw_full = 1'b0;
        for (int i = 0; i < 5 * FRAME + 30; i++) begin
            step(i < 6, 8'($urandom));
            act = {tx_pin, tx_done, tx_busy, tx_ready};
            n_tests++;
            if (act !== exp_vec()) begin
                n_fail++;
                $display("FAIL overflow cyc=%0d pin/done/busy/ready got=%b want=%b", cyc, act, exp_vec());
            end
            if (tx_ready === 1'b0) saw_full = 1'b1;
            if (tx_done === 1'b1) ndone++;
        end
        n_tests++;
        if (ndone !== 5 || !saw_full) begin
            n_fail++;
            $display("FAIL overflow frames got %0d want 5, ready_low_seen=%0d want 1", ndone, saw_full);
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [7:0] bytes [2];
        logic       want_par [2];
        logic [3:0] act;
        int first_low, done_at;
        logic par_seen;
        bytes[0] = 8'h07; want_par[0] = 1'b1;
        bytes[1] = 8'h03; want_par[1] = 1'b0;
        for (int t = 0; t < 2; t++) begin
            first_low = -1; done_at = -1; par_seen = 1'bx;
            for (int i = 0; i < FRAME + 10; i++) begin
                step(i == 0, bytes[t]);
                act = {tx_pin, tx_done, tx_busy, tx_ready};
                n_tests++;
                if (act !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL parity cyc=%0d pin/done/busy/ready got=%b want=%b", cyc, act, exp_vec());
                end
                if (tx_pin === 1'b0 && first_low < 0) first_low = cyc;
                if (first_low >= 0 && cyc - first_low == 9 * B + 1) par_seen = tx_pin;
                if (tx_done === 1'b1) done_at = cyc;
            end
            n_tests++;
            if (par_seen !== want_par[t] || done_at - first_low !== 11 * B) begin
                n_fail++;
                $display("FAIL parity_bit byte=%h got par=%b len=%0d want par=%b len=%0d",
                         bytes[t], par_seen, done_at - first_low, want_par[t], 11 * B);
            end
        end
    endtask
`endif

    task automatic test_reset_mid_frame();
        logic [3:0] act;
        int i;
        // Stop inside data bit 3 (frame bit 4), one cycle into it.
        for (i = 0; i < 100 && !(m_active && m_pos == 4 * B + 1); i++) begin
            step(i < 2, (i == 0) ? 8'hA5 : 8'h3C);
            act = {tx_pin, tx_done, tx_busy, tx_ready};
            n_tests++;
            if (act !== exp_vec()) begin
                n_fail++;
                $display("FAIL midrst cyc=%0d pin/done/busy/ready got=%b want=%b", cyc, act, exp_vec());
            end
        end
        n_tests++;
        if (i >= 100) begin
            n_fail++;
            $display("FAIL midrst_timeout got %0d cycles want <100", i);
        end
        RST = 1'b1;
        #1;
        n_tests++;
        if ({tx_pin, tx_done} !== 2'b10) begin
            n_fail++;
            $display("FAIL midrst_async pin/done got=%b want=10", {tx_pin, tx_done});
        end
        m_q.delete();
        m_active = 1'b0; m_done = 1'b0; m_pos = 0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        n_tests++;
        if ({tx_pin, tx_done, tx_busy, tx_ready} !== 4'b1001) begin
            n_fail++;
            $display("FAIL midrst_held pin/done/busy/ready got=%b want=1001", {tx_pin, tx_done, tx_busy, tx_ready});
        end
        for (int j = 0; j < 2 * FRAME; j++) begin
            step(1'b0, 8'h00);
            act = {tx_pin, tx_done, tx_busy, tx_ready};
            n_tests++;
            if (act !== exp_vec()) begin
                n_fail++;
                $display("FAIL midrst_after cyc=%0d pin/done/busy/ready got=%b want=%b", cyc, act, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] act;
        for (int i = 0; i < 400 + 2000 && (i < 400 || m_active || m_q.size() > 0); i++) begin
            step((i < 400) && ($urandom_range(0, 3) == 0), 8'($urandom));
            act = {tx_pin, tx_done, tx_busy, tx_ready};
            n_tests++;
            if (act !== exp_vec()) begin
                n_fail++;
                $display("FAIL random cyc=%0d pin/done/busy/ready got=%b want=%b", cyc, act, exp_vec());
            end
        end
        n_tests++;
        if (tx_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL random_drain busy got %b want 0", tx_busy);
        end
    endtask

    task automatic test_default_div();
        int mism, done_at, ndone;
        logic want;
        mism = 0; done_at = -1; ndone = 0;
        d_en = 1'b1; d_data = 8'h55;
        @(posedge CLK);
        #1;
        d_en = 1'b0;
        for (int i = 0; i < NBITS * B_DEF + 50; i++) begin
            @(posedge CLK);
            #1;
            want = (i < NBITS * B_DEF) ? frame_bit(8'h55, i / B_DEF) : 1'b1;
            if (d_pin !== want) mism++;
            if (d_done === 1'b1) begin ndone++; done_at = i; end
        end
        n_tests++;
        if (mism !== 0) begin
            n_fail++;
            $display("FAIL default_div bit cells mismatched got %0d cycles want 0", mism);
        end
        n_tests++;
        if (ndone !== 1 || done_at !== NBITS * B_DEF) begin
            n_fail++;
            $display("FAIL default_div done count=%0d at=%0d want 1 at %0d", ndone, done_at, NBITS * B_DEF);
        end
    endtask

    initial begin
        tx_en = 1'b0; tx_data = 8'h00; d_en = 1'b0; d_data = 8'h00;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_overflow();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_reset_mid_frame();
        test_random();
        test_default_div();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not complete, got timeout want finish");
        $fatal(1);
    end

endmodule

// File: doc/uart_tx_module.md
# uart_tx_module

Byte-serial UART transmitter: the send-side counterpart of the serial receive path, for echoing or reporting data back over the same 8N1 serial link. Accepts bytes through a strobe/ready handshake into a small FIFO. Serialises each byte onto `TX_Pin_Out` as start bit, 8 data bits LSB first, optional parity bit, and stop bit. Pulses `TX_Done_Sig` once per completed frame, so a control module can pace or count traffic.

## Interface
Parameters:
- `BAUD_DIV`, default 434: `CLK` cycles per bit (50 MHz / 115200). Legal range is 2 or more.
- `FIFO_DEPTH`, default 4: byte entries buffered. Must be a power of 2 and at least 2.

Ports:
- `CLK`, in, 1: single system clock; all logic is on the rising edge.
- `RST`, in, 1: asynchronous, active-high reset.
- `TX_En_Sig`, in, 1: write strobe. Sampled on a rising edge when `TX_Ready`=1.
- `TX_Data`, in, 8: byte to send. Sampled with `TX_En_Sig`.
- `TX_Ready`, out, 1: FIFO not full.
- `TX_Busy`, out, 1: a frame is on the line, or the FIFO is non-empty.
- `TX_Done_Sig`, out, 1: one-cycle pulse at the end of each stop bit.
- `TX_Pin_Out`, out, 1: serial line, idle high.

## Operation
- Reset values: `TX_Pin_Out`=1, `TX_Ready`=1, `TX_Busy`=0, `TX_Done_Sig`=0. The FIFO is emptied, the FSM goes to IDLE, and the counters go to 0.
- Write handling:
  - A write is accepted when `TX_En_Sig`=1 and the FIFO is not full.
  - A write while full is dropped silently; FIFO contents and count are unchanged.
  - A write and a pop on the same edge are both honoured; the count is unchanged.
- FSM states are IDLE, START, DATA, PARITY (macro only), and STOP.
- IDLE:
  - If the FIFO is non-empty: pop the head byte into the shift register, drive `TX_Pin_Out`=0, and go to START.
  - Otherwise hold `TX_Pin_Out`=1.
- Bit timing:
  - Every bit state holds its pin value for exactly `BAUD_DIV` cycles.
  - The baud counter runs from 0 to `BAUD_DIV`-1 and wraps to 0 on each state transition.
- START goes to DATA with bit index 0. The pin takes the shift register LSB.
- DATA:
  - After each bit, shift right and increment the 3-bit index.
  - After index 7 completes, go to PARITY if the macro is defined, otherwise STOP.
- STOP:
  - Drive the pin to 1.
  - On the final stop cycle, pulse `TX_Done_Sig`.
  - If the FIFO is non-empty on that same edge, pop and go directly to START (pin low). This gives no idle gap between frames.
  - Otherwise go to IDLE.
- `TX_Pin_Out` is driven from a flop. It never glitches and has no combinational path from the inputs.

## Timing
- Latency: a write accepted at edge k into an empty FIFO while IDLE drives `TX_Pin_Out` low from edge k+1.
- Frame length is 10×`BAUD_DIV` cycles, or 11×`BAUD_DIV` with parity.
- `TX_Done_Sig` is high for exactly the one cycle that follows the final stop-bit edge.
- Back-to-back frames: the next start bit begins on the edge that ends the previous stop bit.
- `TX_Ready` updates on the edge after the count change. It falls on the edge the FIFO reaches `FIFO_DEPTH` entries.
- Reset mid-frame: the line goes high immediately (asynchronously). The partial frame is abandoned and `TX_Done_Sig` is not pulsed.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - A PARITY state is inserted after DATA, lasting `BAUD_DIV` cycles.
  - The parity bit is even parity: the XOR of the 8 data bits, captured when the byte is popped.
- `UART_TX_PARITY_EN` undefined: no PARITY state and no parity logic; the frame is 8N1.

## Structure
- Package `uart_pkg`:
  - FSM state enum.
  - Frame constants: data bits = 8, stop bits = 1.
  - Default `BAUD_DIV`.
  - These are shared with the receiver side.
- Sub-module `tx_fifo`:
  - Parameterised by depth.
  - Synchronous write/read, async-high reset.
  - Provides `full`, `empty`, and `count` outputs.
  - Extra pointer bit distinguishes full from empty.
- The top level contains the FSM, baud counter, bit index, and shift register.

## Test plan
All scenarios use `BAUD_DIV`=4 and `FIFO_DEPTH`=4 unless noted.
- **Single byte:** write 0xA5 from idle. Line reads 0, 1,0,1,0,0,1,0,1, 1, each bit 4 cycles. `TX_Done_Sig` pulses once, 40 cycles after the first low.
- **Back-to-back:** write 0x01, 0x02, 0x03 on consecutive cycles. Three frames, 120 cycles, no idle high between stop and start, three done pulses.
- **Overflow:** write 6 bytes on consecutive cycles from idle. Byte 0 is popped at once. Bytes 1–4 fill the FIFO, `TX_Ready` goes 0, and byte 5 is dropped. Exactly 5 frames are transmitted.
- **Reset mid-frame:** assert `RST` during data bit 3. `TX_Pin_Out`=1 at once, no done pulse. After release the FIFO is empty and `TX_Busy`=0.
- **Parity (macro defined):** write 0x07. Parity bit = 1 and the frame is 44 cycles. With 0x03, parity bit = 0.
- **Default divider:** `BAUD_DIV`=434, byte 0x55. Each bit measures exactly 434 cycles.
